mips_div_unit: RTL

//  Multi-cycle radix-2 restoring divider for the EX stage, executing MIPS DIV and DIVU.
//  EX issues operands on start and holds them. The block raises stallreq_for_ex to the

---
 rtl/mips_div_unit_pkg.sv | 11 +
 rtl/mips_div_unit_div_step.sv | 20 ++
 rtl/mips_div_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/mips_div_unit_pkg.sv
// mips_div_unit_pkg: shared widths and divider state encoding.
package mips_div_unit_pkg;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W = 6;
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;
endpackage

// File: rtl/mips_div_unit_div_step.sv
// mips_div_unit_div_step: one restoring-division trial subtract.
module mips_div_unit_div_step
  import mips_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              din,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q
);
  logic [DATA_W:0] trial;
  // rem < divisor always holds, so bit DATA_W of the difference is a clean borrow flag
  always_comb begin
    trial = {rem, din} - {1'b0, divisor};
    q = ~trial[DATA_W];
    rem_next = q ? trial[DATA_W-1:0] : {rem[DATA_W-2:0], din};
  end
endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
module mips_div_unit
  import mips_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                annul,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                stallreq_for_ex
);
  div_state_e state, state_nxt;
  logic [DATA_W-1:0] dividend, divisor, rem, rem_next, quo, quo_fix, rem_fix;
  logic [CNT_W-1:0] cnt;
  logic q, sign1, sign2, last;

  mips_div_unit_div_step #(.DATA_W(DATA_W)) u_step (
    .rem(rem),
    .din(dividend[DATA_W-1]),
    .divisor(divisor),
    .rem_next(rem_next),
    .q(q)
  );

  // dividend shifts out its msb each step and collects quotient bits at the lsb
  always_comb begin
    last = cnt == CNT_W'(DATA_W - 1);
    quo = {dividend[DATA_W-2:0], q};
    quo_fix = (sign1 ^ sign2) ? -quo : quo;
    rem_fix = sign1 ? -rem_next : rem_next;
    stallreq_for_ex = start & ~ready & ~annul;
  end

  always_comb begin
    state_nxt = annul ? DIV_FREE :
                state == DIV_FREE ? (start ? (opdata2 == '0 ? DIV_BYZERO : DIV_ON) : DIV_FREE) :
                state == DIV_BYZERO ? DIV_END :
                state == DIV_ON ? (last ? DIV_END : DIV_ON) :
                start ? DIV_END : DIV_FREE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_FREE;
    else state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dividend <= '0;
      divisor <= '0;
      rem <= '0;
      cnt <= '0;
      sign1 <= 1'b0;
      sign2 <= 1'b0;
      result <= '0;
      ready <= 1'b0;
    end else if (annul) begin
      ready <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready <= 1'b0;
          result <= '0;
          if (start && opdata2 != '0) begin
            dividend <= (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
            divisor <= (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
            sign1 <= signed_div & opdata1[DATA_W-1];
            sign2 <= signed_div & opdata2[DATA_W-1];
            rem <= '0;
            cnt <= '0;
          end
        end
        DIV_BYZERO: result <= '0;
        DIV_ON: begin
          dividend <= quo;
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (last) result <= {rem_fix, quo_fix};
        end
        DIV_END: begin
          ready <= start;
          if (!start) result <= '0;
        end
      endcase
    end
  end
endmodule
